// File: rtl/serial_deser_pkg.sv
// Shared types and sizing helpers for the serial SIPO receiver.
// The optional parity stage is enabled by defining PARITY_CHECK_EN.
package serial_deser_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_t;

  // Bit counter width: wide enough to hold WIDTH itself.
  function automatic int CNT_W(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/deser_out_reg.sv
// Single-entry holding register for completed words with valid/ready drain.
// A word offered while the entry is full and not draining is dropped and flagged.
module deser_out_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_perr,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_valid,
  output logic             o_perr,
  output logic             o_overflow
);

  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_perr;
  logic             r_overflow;
  logic             w_xfer;
  logic             w_accept;

  // Handshake: a word moves out on every rising edge where o_valid && i_ready;
  // o_valid never drops without that transfer, and o_dout is stable while o_valid.
  assign w_xfer   = r_valid && i_ready;
  assign w_accept = !r_valid || w_xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout     <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (i_load) begin
      if (w_accept) begin
        r_dout  <= i_word;
        r_valid <= 1'b1;
        r_perr  <= i_perr;
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  assign o_dout     = r_dout;
  assign o_valid    = r_valid;
  assign o_perr     = r_perr;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/serial_deserializer_sipo.sv
// Serial-in/parallel-out receiver: LSB-first word assembly into a holding register.
// Define PARITY_CHECK_EN to expect an even-parity bit after each data word.
module serial_deserializer_sipo
  import serial_deser_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overflow,
  output logic             parity_err,
  output state_t           dbg_state
);

  localparam int CW = CNT_W(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bit_cnt;
  state_t           r_state;

  logic [CW-1:0]    w_cnt_base;
  state_t           w_state_base;
  logic [CW-1:0]    w_cnt_nxt;
  state_t           w_state_nxt;
  logic             w_shift;
  logic             w_load;
  logic [WIDTH-1:0] w_word;
  logic             w_perr;

  // sync restarts the frame before this edge's sample is considered.
  always_comb begin
    w_cnt_base   = sync ? '0 : r_bit_cnt;
    w_state_base = sync ? COLLECT : r_state;
  end

  always_comb begin
    w_state_nxt = w_state_base;
    w_cnt_nxt   = w_cnt_base;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    w_word      = r_shreg;
    w_perr      = 1'b0;
    if (sin_valid) begin
      case (w_state_base)
        COLLECT: begin
          w_shift = 1'b1;
          w_word  = {sin, r_shreg[WIDTH-1:1]};
          if (w_cnt_base == LAST_BIT) begin
            w_cnt_nxt = '0;
`ifdef PARITY_CHECK_EN
            w_state_nxt = PARITY;
`else
            w_load = 1'b1;
`endif
          end else begin
            w_cnt_nxt = w_cnt_base + 1'b1;
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          // Data is already complete in r_shreg; the parity bit is not shifted in.
          w_load      = 1'b1;
          w_word      = r_shreg;
          w_perr      = ^{r_shreg, sin};
          w_cnt_nxt   = '0;
          w_state_nxt = COLLECT;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_state   <= COLLECT;
    end else begin
      if (w_shift) r_shreg <= {sin, r_shreg[WIDTH-1:1]};
      r_bit_cnt <= w_cnt_nxt;
      r_state   <= w_state_nxt;
    end
  end

  deser_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_word    (w_word),
    .i_perr    (w_perr),
    .i_ready   (dout_ready),
    .o_dout    (dout),
    .o_valid   (dout_valid),
    .o_perr    (parity_err),
    .o_overflow(overflow)
  );

  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_deserializer_sipo.sv
// Bench for serial_deserializer_sipo (WIDTH=4); define PARITY_CHECK_EN to cover the parity stage.
module tb_serial_deserializer_sipo;
  import serial_deser_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         sin;
  logic         sin_valid;
  logic         sync;
  logic         dout_ready;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         overflow;
  logic         parity_err;
  state_t       dbg_state;

  int checks   = 0;
  int failures = 0;

  serial_deserializer_sipo #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sync      (sync),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .overflow  (overflow),
    .parity_err(parity_err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Model: list of bits received in the current frame, plus a one-slot holder.
  bit           m_init = 1'b0;
  int           m_n;
  bit           m_in_par;
  logic [W-1:0] m_data;
  logic [W-1:0] m_dout;
  logic         m_valid;
  logic         m_perr;
  logic         m_ovf;

  always @(posedge clk) begin
    bit           comp;
    bit           xfer;
    logic [W-1:0] word;
    logic         perr;
    comp = 1'b0;
    word = '0;
    perr = 1'b0;
    if (reset) begin
      m_init = 1'b1; m_n = 0; m_in_par = 1'b0; m_data = '0;
      m_dout = '0; m_valid = 1'b0; m_perr = 1'b0; m_ovf = 1'b0;
    end else if (m_init) begin
      xfer = m_valid && dout_ready;
      if (sync) begin
        m_n = 0;
        m_in_par = 1'b0;
      end
      if (sin_valid) begin
        if (m_in_par) begin
          comp = 1'b1; word = m_data; perr = (^m_data) ^ sin;
          m_in_par = 1'b0;
        end else begin
          m_data[m_n] = sin;
          m_n++;
          if (m_n == W) begin
            m_n = 0;
`ifdef PARITY_CHECK_EN
            m_in_par = 1'b1;
`else
            comp = 1'b1; word = m_data;
`endif
          end
        end
      end
      if (comp) begin
        if (!m_valid || xfer) begin
          m_dout = word; m_valid = 1'b1; m_perr = perr;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (xfer) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_init) begin
      checks++;
      if (dout_valid !== m_valid) begin
        failures++;
        $display("FAIL cyc_valid t=%0t act=%b exp=%b", $time, dout_valid, m_valid);
      end
      checks++;
      if (overflow !== m_ovf) begin
        failures++;
        $display("FAIL cyc_overflow t=%0t act=%b exp=%b", $time, overflow, m_ovf);
      end
      checks++;
      if (dout !== m_dout) begin
        failures++;
        $display("FAIL cyc_dout t=%0t act=%h exp=%h", $time, dout, m_dout);
      end
      if (m_valid) begin
        checks++;
        if (parity_err !== m_perr) begin
          failures++;
          $display("FAIL cyc_parity t=%0t act=%b exp=%b", $time, parity_err, m_perr);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic b, input logic s, input logic r);
    sin_valid  = v;
    sin        = b;
    sync       = s;
    dout_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Parity bit that makes {data, p} even; only sent when the parity stage exists.
  task automatic frame_end(input logic [W-1:0] w, input logic r);
`ifdef PARITY_CHECK_EN
    cyc(1'b1, ^w, 1'b0, r);
`else
    if (w === 'x) cyc(1'b0, 1'b0, 1'b0, r);
`endif
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic r);
    for (int i = 0; i < W; i++) cyc(1'b1, w[i], 1'b0, r);
    frame_end(w, r);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0; dout_ready = 1'b0;
    do_reset(2);
    chk("reset_dout", 32'(dout), 32'h0);
    chk("reset_valid", 32'(dout_valid), 32'h0);
    chk("reset_state", 32'(dbg_state), 32'(COLLECT));

    // Back-to-back bits 1,0,1,1 with a ready consumer.
    send_word(4'b1101, 1'b1);
    chk("t2_valid", 32'(dout_valid), 32'h1);
    chk("t2_dout", 32'(dout), 32'hD);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_valid_drop", 32'(dout_valid), 32'h0);

    // Same bits with idle gaps of 1..3 cycles.
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_not_yet", 32'(dout_valid), 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    frame_end(4'b1101, 1'b1);
    chk("t3_valid", 32'(dout_valid), 32'h1);
    chk("t3_dout", 32'(dout), 32'hD);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Stalled consumer: second word is dropped.
    send_word(4'hA, 1'b0);
    send_word(4'h5, 1'b0);
    chk("t4_dout", 32'(dout), 32'hA);
    chk("t4_overflow", 32'(overflow), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_drained", 32'(dout_valid), 32'h0);

    // Drain and refill on the same edge: no bubble.
    send_word(4'h3, 1'b0);
    for (int i = 0; i < W - 1; i++) cyc(1'b1, i[0], 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    frame_end(4'b1010, 1'b1);
    chk("fill_dout", 32'(dout), 32'hA);

    // Reset mid-frame, then a fresh frame starts at bit 0.
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    do_reset(2);
    chk("t1_dout", 32'(dout), 32'h0);
    chk("t1_valid", 32'(dout_valid), 32'h0);
    chk("t1_overflow", 32'(overflow), 32'h0);
    send_word(4'b1101, 1'b1);
    chk("t1_next_dout", 32'(dout), 32'hD);

    // sync discards a partial frame; the sync-edge bit is bit 0.
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    frame_end(4'b0100, 1'b1);
    chk("t5_dout", 32'(dout), 32'h4);
    chk("t5_overflow", 32'(overflow), 32'h0);

`ifdef PARITY_CHECK_EN
    for (int i = 0; i < W; i++) cyc(1'b1, i[0] == 1'b0 || i == 3, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t6_perr_ok", 32'(parity_err), 32'h0);
    for (int i = 0; i < W; i++) cyc(1'b1, i[0] == 1'b0 || i == 3, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t6_perr_bad", 32'(parity_err), 32'h1);
    chk("t6_dout", 32'(dout), 32'hD);
`endif

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
